window_assembler_3x3: RTL and testbench

WINDOW_ASSEMBLER_3X3 -- requirements
Module: window_assembler_3x3

---
 rtl/input_layer_pkg.sv | 32 +++
 rtl/window_assembler_3x3_if.sv | 32 +++
 rtl/window_out_reg.sv | 48 ++++
 rtl/window_assembler_3x3.sv | 138 +++++++++++++
 tb/tb_window_assembler_3x3.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_layer_pkg.sv
// Shared widths, state encoding and window payload type for the 3x3 window assembler.
package input_layer_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned TAP_W  = 3 * PIX_W;
    localparam int unsigned WIN_W  = 3 * TAP_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FCNT_W = 4;

    // Minimum row-FIFO occupancy needed before a 3-pixel tap may be popped
    localparam logic [FCNT_W-1:0] MIN_TAPS = FCNT_W'(3);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] ROW_END = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_RUN     = RUN,
        ST_ROW_END = ROW_END,
        ST_DRAIN   = DRAIN
    } state_e;

    // Window payload, top row in the most significant tap
    typedef struct packed {
        logic [TAP_W-1:0] top;
        logic [TAP_W-1:0] mid;
        logic [TAP_W-1:0] bot;
    } window_t;

endpackage

// File: rtl/window_assembler_3x3_if.sv
// Row-FIFO tap bus plus window valid/ready handshake of the 3x3 window assembler.
interface window_assembler_3x3_if;
    import input_layer_pkg::*;

    logic [TAP_W-1:0]  fifo_data0;
    logic [TAP_W-1:0]  fifo_data1;
    logic [TAP_W-1:0]  fifo_data2;
    logic [FCNT_W-1:0] fifo_count0;
    logic [FCNT_W-1:0] fifo_count1;
    logic [FCNT_W-1:0] fifo_count2;
    logic              fifo_pop;
    logic [WIN_W-1:0]  window_data;
    logic              window_valid;
    logic              window_ready;

    // Assembler side
    modport master (
        input  fifo_data0, fifo_data1, fifo_data2,
        input  fifo_count0, fifo_count1, fifo_count2,
        input  window_ready,
        output fifo_pop, window_data, window_valid
    );

    // FIFO/consumer side
    modport slave (
        output fifo_data0, fifo_data1, fifo_data2,
        output fifo_count0, fifo_count1, fifo_count2,
        output window_ready,
        input  fifo_pop, window_data, window_valid
    );

endinterface

// File: rtl/window_out_reg.sv
// One-deep valid/ready output register holding the assembled 3x3 window.
module window_out_reg
    import input_layer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIN_W-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIN_W-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIN_W-1:0] data_q;
    logic [WIN_W-1:0] data_d;

    // Clear beats load; a load refills the slot; ready alone empties it
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/window_assembler_3x3.sv
// Pops 3-pixel taps from three row FIFOs and emits 72-bit 3x3 windows, row by row.
module window_assembler_3x3
    import input_layer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stride2en,
    input  logic [CNT_W-1:0]       row_len,
    input  logic [CNT_W-1:0]       num_rows,
    window_assembler_3x3_if.master bus,
    output logic                   row_done,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   stride2_mode
);

    state_e           state_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] row_len_q;
    logic [CNT_W-1:0] num_rows_q;
    logic             stride2_q;
    logic             row_done_q;
    logic             frame_done_q;
    logic             busy_q;

    logic             taps_ok;
    logic             slot_free;
    logic             abort;
    logic             pop;
    logic             last_col;
    logic             last_row;
    window_t          win_tap;

    // Pop qualification; a start in flight never pops so an aborted frame consumes nothing
    assign taps_ok   = (bus.fifo_count0 >= MIN_TAPS) &&
                       (bus.fifo_count1 >= MIN_TAPS) &&
                       (bus.fifo_count2 >= MIN_TAPS);
    assign slot_free = !bus.window_valid || bus.window_ready;
    assign abort     = start && (state_q != ST_IDLE);
    assign pop       = (state_q == ST_RUN) && !start && taps_ok && slot_free;
    assign last_col  = (col_q == CNT_W'(row_len_q - CNT_W'(1)));
    assign last_row  = (CNT_W'(row_q + CNT_W'(1)) == num_rows_q);

    assign win_tap.top = bus.fifo_data0;
    assign win_tap.mid = bus.fifo_data1;
    assign win_tap.bot = bus.fifo_data2;

    assign bus.fifo_pop = pop;

    window_out_reg u_out (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (pop),
        .clear_i (abort),
        .data_i  (win_tap),
        .ready_i (bus.window_ready),
        .valid_o (bus.window_valid),
        .data_o  (bus.window_data)
    );

    // Frame sequencing: column/row counters, row and frame pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row_len_q    <= '0;
            num_rows_q   <= '0;
            stride2_q    <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;

            if (start) begin
                row_len_q  <= row_len;
                num_rows_q <= num_rows;
                stride2_q  <= stride2en;
                col_q      <= '0;
                row_q      <= '0;
            end

            if (abort) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if ((row_len == '0) || (num_rows == '0)) begin
                                frame_done_q <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (pop) begin
                            if (last_col) begin
                                col_q      <= '0;
                                state_q    <= ST_ROW_END;
                                row_done_q <= 1'b1;
                            end else begin
                                col_q <= CNT_W'(col_q + CNT_W'(1));
                            end
                        end
                    end
                    ST_ROW_END: begin
                        row_q   <= CNT_W'(row_q + CNT_W'(1));
                        state_q <= last_row ? ST_DRAIN : ST_RUN;
                    end
                    ST_DRAIN: begin
                        if (slot_free) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_done     = row_done_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign stride2_mode = stride2_q;

endmodule

// File: tb/tb_window_assembler_3x3.sv
// Self-checking bench for window_assembler_3x3: directed table, corner sequences, random frames.
module tb_window_assembler_3x3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stride2en;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       row_done;
    logic       frame_done;
    logic       busy;
    logic       stride2_mode;

    window_assembler_3x3_if bus_if ();

    window_assembler_3x3 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stride2en    (stride2en),
        .row_len      (row_len),
        .num_rows     (num_rows),
        .bus          (bus_if),
        .row_done     (row_done),
        .frame_done   (frame_done),
        .busy         (busy),
        .stride2_mode (stride2_mode)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [71:0] sb_q[$];
    int          pops_in_row = 0;
    int          rows_done   = 0;
    int          n_pop = 0, n_rd = 0, n_fd = 0, n_acc = 0;
    logic [7:0]  cfg_rl = 8'd0, cfg_nr = 8'd0;
    bit          in_frame = 0, zero_pending = 0, prev_hold = 0;
    bit          m_legal, m_taps;
    logic [71:0] prev_data, last_acc;

    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            in_frame = 0; zero_pending = 0; prev_hold = 0;
            pops_in_row = 0; rows_done = 0;
        end else begin
            check("valid_vs_model", 72'(bus_if.window_valid), 72'(sb_q.size() != 0));
            if (prev_hold && bus_if.window_valid)
                check("hold_stable", bus_if.window_data, prev_data);
            if (bus_if.window_valid && bus_if.window_ready && sb_q.size() != 0) begin
                check("window_order", bus_if.window_data, sb_q[0]);
                last_acc = bus_if.window_data;
                void'(sb_q.pop_front());
                n_acc++;
            end
            m_taps  = (bus_if.fifo_count0 >= 4'd3) && (bus_if.fifo_count1 >= 4'd3) &&
                      (bus_if.fifo_count2 >= 4'd3);
            m_legal = in_frame && !start && m_taps &&
                      (!bus_if.window_valid || bus_if.window_ready) &&
                      (pops_in_row < int'(cfg_rl)) && (rows_done < int'(cfg_nr));
            if (bus_if.fifo_pop) begin
                check("pop_legal", 72'(m_legal), 72'(1));
                sb_q.push_back({bus_if.fifo_data0, bus_if.fifo_data1, bus_if.fifo_data2});
                pops_in_row++;
                n_pop++;
            end
            if (row_done) begin
                check("pops_per_row", 72'(pops_in_row), 72'(cfg_rl));
                pops_in_row = 0;
                rows_done++;
                n_rd++;
            end
            if (frame_done) begin
                check("frame_done_legal",
                      72'(zero_pending || (in_frame && rows_done == int'(cfg_nr) && sb_q.size() == 0)),
                      72'(1));
                in_frame = 0;
                n_fd++;
            end
            zero_pending = 0;
            check("busy_vs_model", 72'(busy), 72'(in_frame));
            prev_hold = bus_if.window_valid && !bus_if.window_ready;
            prev_data = bus_if.window_data;
            if (start) begin
                sb_q.delete();
                cfg_rl = row_len;
                cfg_nr = num_rows;
                pops_in_row = 0;
                rows_done = 0;
                zero_pending = (row_len == 8'd0 || num_rows == 8'd0) && !in_frame;
                in_frame = (row_len != 8'd0) && (num_rows != 8'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_counts(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
        bus_if.fifo_count0 = c0;
        bus_if.fifo_count1 = c1;
        bus_if.fifo_count2 = c2;
    endtask

    task automatic randomize_inputs();
        bus_if.fifo_data0   = 24'($urandom);
        bus_if.fifo_data1   = 24'($urandom);
        bus_if.fifo_data2   = 24'($urandom);
        bus_if.fifo_count0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 8)) : 4'd8;
        bus_if.fifo_count1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 8)) : 4'd8;
        bus_if.fifo_count2  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 8)) : 4'd8;
        bus_if.window_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge, config scrambled
    task automatic pulse_start(input logic [7:0] rl, input logic [7:0] nr, input logic s2);
        row_len = rl; num_rows = nr; stride2en = s2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stride2en = ~s2; row_len = ~rl; num_rows = ~nr;
    endtask

    // idx = cycles after the start edge at which frame_done is seen, -1 on timeout
    task automatic wait_frame(input int budget, input bit rnd, output int idx);
        idx = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done) begin
                idx = k;
                break;
            end
            @(posedge clk); #1;
            if (rnd) randomize_inputs();
        end
        check("frame_done_seen", 72'(idx >= 0), 72'(1));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  rl;
        logic [7:0]  nr;
        logic        s2;
        logic [23:0] d0, d1, d2;
        logic [71:0] exp_win;
        int          exp_fd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, pop0, rd0, fd0, exp_rd;

        vecs[0] = '{8'd4, 8'd2, 1'b0, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 72'hA1A2A3B1B2B3C1C2C3, 11};
        vecs[1] = '{8'd1, 8'd1, 1'b0, 24'h123456, 24'h789ABC, 24'hDEF012, 72'h123456789ABCDEF012, 3};
        vecs[2] = '{8'd3, 8'd3, 1'b1, 24'h00FF00, 24'hFF00FF, 24'h0F0F0F, 72'h00FF00FF00FF0F0F0F, 13};
        vecs[3] = '{8'd0, 8'd5, 1'b0, 24'h111111, 24'h222222, 24'h333333, 72'h0, 0};
        vecs[4] = '{8'd2, 8'd0, 1'b1, 24'h444444, 24'h555555, 24'h666666, 72'h0, 0};
        vecs[5] = '{8'd6, 8'd1, 1'b1, 24'h010203, 24'h040506, 24'h070809, 72'h010203040506070809, 8};

        reset_n = 1'b0; start = 1'b0; stride2en = 1'b0; row_len = 8'd0; num_rows = 8'd0;
        bus_if.fifo_data0 = '0; bus_if.fifo_data1 = '0; bus_if.fifo_data2 = '0;
        set_counts(4'd8, 4'd8, 4'd8);
        bus_if.window_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 72'(bus_if.window_valid), 72'(0));
        check("rst_data", bus_if.window_data, 72'(0));
        check("rst_pop", 72'(bus_if.fifo_pop), 72'(0));
        check("rst_row_done", 72'(row_done), 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed frame table: full-rate ready, ample FIFO occupancy
        foreach (vecs[i]) begin
            bus_if.fifo_data0 = vecs[i].d0;
            bus_if.fifo_data1 = vecs[i].d1;
            bus_if.fifo_data2 = vecs[i].d2;
            set_counts(4'd8, 4'd8, 4'd8);
            bus_if.window_ready = 1'b1;
            pop0 = n_pop; rd0 = n_rd;
            pulse_start(vecs[i].rl, vecs[i].nr, vecs[i].s2);
            check("stride2_latched", 72'(stride2_mode), 72'(vecs[i].s2));
            wait_frame(200, 1'b0, idx);
            exp_rd = (vecs[i].rl != 8'd0) ? int'(vecs[i].nr) : 0;
            check("tbl_frame_done_cycle", 72'(idx), 72'(vecs[i].exp_fd));
            check("tbl_pop_count", 72'(n_pop - pop0), 72'(int'(vecs[i].rl) * int'(vecs[i].nr)));
            check("tbl_row_done_count", 72'(n_rd - rd0), 72'(exp_rd));
            check("tbl_stride2_held", 72'(stride2_mode), 72'(vecs[i].s2));
            if (int'(vecs[i].rl) * int'(vecs[i].nr) > 0)
                check("tbl_window_data", last_acc, vecs[i].exp_win);
        end

        // Consumer stall: no pop and stable data while ready is low, pop resumes with ready
        bus_if.window_ready = 1'b0;
        pulse_start(8'd8, 8'd1, 1'b0);
        @(negedge clk);
        check("stall_first_pop", 72'(bus_if.fifo_pop), 72'(1));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus_if.fifo_data0 = 24'($urandom);
            @(negedge clk);
            check("stall_no_pop", 72'(bus_if.fifo_pop), 72'(0));
            check("stall_valid", 72'(bus_if.window_valid), 72'(1));
        end
        @(posedge clk); #1;
        bus_if.window_ready = 1'b1;
        @(negedge clk);
        check("stall_resume_pop", 72'(bus_if.fifo_pop), 72'(1));
        @(posedge clk); #1;
        wait_frame(200, 1'b0, idx);

        // FIFO underflow: one FIFO at 2 entries blocks popping until it reaches 3
        set_counts(4'd8, 4'd2, 4'd8);
        pulse_start(8'd3, 8'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("low_count_no_pop", 72'(bus_if.fifo_pop), 72'(0));
            check("low_count_no_valid", 72'(bus_if.window_valid), 72'(0));
            @(posedge clk); #1;
        end
        set_counts(4'd8, 4'd3, 4'd8);
        @(negedge clk);
        check("count_ok_pop", 72'(bus_if.fifo_pop), 72'(1));
        @(posedge clk); #1;
        wait_frame(200, 1'b0, idx);
        check("low_count_frame_cycle", 72'(idx), 72'(4));
        set_counts(4'd8, 4'd8, 4'd8);

        // Abort at col 2 of row 1, new frame must run clean from zeroed counters
        pulse_start(8'd4, 8'd3, 1'b0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rd0 = n_rd; fd0 = n_fd;
        pulse_start(8'd2, 8'd2, 1'b0);
        check("abort_valid_cleared", 72'(bus_if.window_valid), 72'(0));
        wait_frame(100, 1'b0, idx);
        check("abort_frame_cycle", 72'(idx), 72'(7));
        check("abort_row_done_count", 72'(n_rd - rd0), 72'(2));
        check("abort_frame_done_count", 72'(n_fd - fd0), 72'(1));

        // Asynchronous reset mid-RUN with a pending window
        bus_if.window_ready = 1'b0;
        pulse_start(8'd4, 8'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_valid", 72'(bus_if.window_valid), 72'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_valid", 72'(bus_if.window_valid), 72'(0));
        check("areset_data", bus_if.window_data, 72'(0));
        check("areset_pop", 72'(bus_if.fifo_pop), 72'(0));
        check("areset_busy", 72'(busy), 72'(0));
        check("areset_row_done", 72'(row_done), 72'(0));
        check("areset_frame_done", 72'(frame_done), 72'(0));
        bus_if.window_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_idle_no_pop", 72'(bus_if.fifo_pop), 72'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_idle_no_pop", 72'(bus_if.fifo_pop), 72'(0));
        check("post_reset_busy", 72'(busy), 72'(0));
        @(posedge clk); #1;

        // Randomized frames checked by the scoreboard model
        for (int f = 0; f < 25; f++) begin
            logic [7:0] rl, nr;
            rl = 8'($urandom_range(1, 6));
            nr = 8'($urandom_range(1, 4));
            randomize_inputs();
            pop0 = n_pop; rd0 = n_rd;
            pulse_start(rl, nr, 1'($urandom_range(0, 1)));
            randomize_inputs();
            wait_frame(3000, 1'b1, idx);
            check("rnd_pop_count", 72'(n_pop - pop0), 72'(int'(rl) * int'(nr)));
            check("rnd_row_done_count", 72'(n_rd - rd0), 72'(nr));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
